vball: RTL and testbench

Vertical ball motion and video generator for the Pong playfield. It counts scan lines within a frame and holds the ball's vertical position, advancing it once per frame by a signed velocity. The velocity is taken from the paddle segment struck on each hit, and its direction reverses at the top and bottom walls. `VVID_N` is the vertical half of the ball video and is combined downstream with the horizontal ball video `HVID_N`.

---
 rtl/vball_if.sv | 21 ++
 rtl/vball.sv | 120 ++++++++++++
 tb/tb_vball.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/vball_if.sv
// Ball vertical-motion bus: playfield timing and paddle-hit inputs, ball video and direction outputs.
interface vball_if;
  logic       hreset;
  logic       vreset;
  logic       hit_n;
  logic [2:0] pad_seg;
  logic       serve;
  logic       vvid_n;
  logic       v_up;
  logic       hit_wall;

  modport master (
    output hreset, vreset, hit_n, pad_seg, serve,
    input  vvid_n, v_up, hit_wall
  );

  modport slave (
    input  hreset, vreset, hit_n, pad_seg, serve,
    output vvid_n, v_up, hit_wall
  );
endinterface

// File: rtl/vball.sv
// vball: vertical ball motion and ball video for the Pong playfield.
// Counts scan lines, moves the ball once per frame by a signed velocity
// latched from the struck paddle segment, and bounces off top/bottom walls.
// Optional build macro VBALL_WALL_SOUND_EN adds a one-cycle hit_wall pulse
// on every wall bounce; without it hit_wall is tied low.
module vball #(
  parameter int unsigned LINES_PER_FRAME = 262,
  parameter int unsigned TOP_LINE        = 16,
  parameter int unsigned BOTTOM_LINE     = 255,
  parameter int unsigned BALL_H          = 4,
  parameter int unsigned SERVE_LINE      = 128
) (
  input  logic   clk_drv,
  input  logic   rst,
  vball_if.slave bus
);

  localparam int unsigned POS_W = 9;
  localparam int unsigned EXT_W = 10;

  localparam logic [POS_W-1:0]        LINE_LAST = POS_W'(LINES_PER_FRAME - 1);
  localparam logic [POS_W-1:0]        SERVE_POS = POS_W'(SERVE_LINE);
  localparam logic signed [EXT_W-1:0] TOP_S     = EXT_W'(TOP_LINE);
  localparam logic signed [EXT_W-1:0] BOT_S     = EXT_W'(BOTTOM_LINE - BALL_H + 1);
  localparam logic [EXT_W-1:0]        HEIGHT    = EXT_W'(BALL_H);

  logic                    hreset_q, vreset_q, hit_n_q;
  logic                    h_ev_c, v_ev_c, hit_ev_c;
  logic [POS_W-1:0]        line, line_nx;
  logic [POS_W-1:0]        vpos, vpos_nx;
  logic [1:0]              mag, mag_nx;
  logic                    v_up, v_up_nx;
  logic                    vvid_n;
  logic signed [EXT_W-1:0] step_pos_c;
  logic                    lo_clamp_c, hi_clamp_c;

  // Edge events, line counter, position step with wall clamps, velocity latch
  always_comb begin
    h_ev_c     = bus.hreset & ~hreset_q;
    v_ev_c     = bus.vreset & ~vreset_q;
    hit_ev_c   = ~bus.hit_n & hit_n_q;
    line_nx    = line;
    vpos_nx    = vpos;
    mag_nx     = mag;
    v_up_nx    = v_up;
    step_pos_c = v_up ? signed'({1'b0, vpos} - {8'd0, mag})
                      : signed'({1'b0, vpos} + {8'd0, mag});
    lo_clamp_c = step_pos_c < TOP_S;
    hi_clamp_c = step_pos_c > BOT_S;

    if (v_ev_c) begin
      line_nx = '0;
    end else if (h_ev_c) begin
      line_nx = (line == LINE_LAST) ? '0 : line + POS_W'(1);
    end

    if (v_ev_c && !bus.serve) begin
      if (lo_clamp_c) begin
        vpos_nx = TOP_S[POS_W-1:0];
        v_up_nx = 1'b0;
      end else if (hi_clamp_c) begin
        vpos_nx = BOT_S[POS_W-1:0];
        v_up_nx = 1'b1;
      end else begin
        vpos_nx = step_pos_c[POS_W-1:0];
      end
    end

    // A hit in the same cycle as the frame step overrides any bounce direction
    if (hit_ev_c) begin
      v_up_nx = ~bus.pad_seg[2];
      mag_nx  = bus.pad_seg[2] ? bus.pad_seg[1:0] : ~bus.pad_seg[1:0];
    end
  end

  // State registers and registered ball video
  always_ff @(posedge clk_drv or posedge rst) begin
    if (rst) begin
      hreset_q <= 1'b0;
      vreset_q <= 1'b0;
      hit_n_q  <= 1'b0;
      line     <= '0;
      vpos     <= SERVE_POS;
      mag      <= '0;
      v_up     <= 1'b0;
      vvid_n   <= 1'b1;
    end else begin
      hreset_q <= bus.hreset;
      vreset_q <= bus.vreset;
      hit_n_q  <= bus.hit_n;
      line     <= line_nx;
      vpos     <= vpos_nx;
      mag      <= mag_nx;
      v_up     <= v_up_nx;
      vvid_n   <= ~(({1'b0, line} >= {1'b0, vpos}) &&
                    ({1'b0, line} <  ({1'b0, vpos} + HEIGHT)));
    end
  end

  assign bus.vvid_n = vvid_n;
  assign bus.v_up   = v_up;

`ifdef VBALL_WALL_SOUND_EN
  logic hit_wall;

  // One-cycle pulse alongside the direction change on a wall bounce
  always_ff @(posedge clk_drv or posedge rst) begin
    if (rst) begin
      hit_wall <= 1'b0;
    end else begin
      hit_wall <= v_ev_c & ~bus.serve & (lo_clamp_c | hi_clamp_c);
    end
  end

  assign bus.hit_wall = hit_wall;
`else
  assign bus.hit_wall = 1'b0;
`endif

endmodule

// File: tb/tb_vball.sv
// tb_vball: directed self-checking bench for vball.
module tb_vball;

  logic clk_drv = 1'b0;
  logic rst     = 1'b1;
  int   errors  = 0;
  int   checks  = 0;
  int   wall_cnt = 0;
  int   w0;

`ifdef VBALL_WALL_SOUND_EN
  localparam int WALL_EXP = 1;
`else
  localparam int WALL_EXP = 0;
`endif

  vball_if bus();

  vball dut (
    .clk_drv (clk_drv),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_drv = ~clk_drv;

  // Count cycles with hit_wall high
  always @(negedge clk_drv) begin
    if (bus.hit_wall) wall_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic hpulse();
    @(negedge clk_drv); bus.hreset = 1'b1;
    repeat (2) @(negedge clk_drv); bus.hreset = 1'b0;
    repeat (2) @(negedge clk_drv);
  endtask

  task automatic vpulse();
    @(negedge clk_drv); bus.vreset = 1'b1;
    repeat (2) @(negedge clk_drv); bus.vreset = 1'b0;
    repeat (2) @(negedge clk_drv);
  endtask

  task automatic hit(input logic [2:0] seg);
    @(negedge clk_drv); bus.pad_seg = seg; bus.hit_n = 1'b0;
    repeat (2) @(negedge clk_drv); bus.hit_n = 1'b1;
    repeat (2) @(negedge clk_drv);
  endtask

  initial begin
    bus.hreset  = 1'b0;
    bus.vreset  = 1'b0;
    bus.hit_n   = 1'b1;
    bus.pad_seg = 3'd0;
    bus.serve   = 1'b0;
    repeat (3) @(negedge clk_drv);

    // Reset state
    chk("rst_line", dut.line, 0);
    chk("rst_vpos", dut.vpos, 128);
    chk("rst_mag", dut.mag, 0);
    chk("rst_v_up", bus.v_up, 0);
    chk("rst_vvid_n", bus.vvid_n, 1);
    chk("rst_hit_wall", bus.hit_wall, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk_drv);
    chk("line0_vvid_n", bus.vvid_n, 1);

    // Ball video over lines 1..130 with ball at 128
    for (int k = 1; k <= 130; k++) begin
      hpulse();
      chk($sformatf("vvid_line%0d", k), bus.vvid_n, (k >= 128 && k <= 131) ? 0 : 1);
    end
    chk("scan_line", dut.line, 130);
    chk("scan_v_up", bus.v_up, 0);

    // Downward mag 2
    hit(3'd6);
    chk("seg6_mag", dut.mag, 2);
    for (int k = 1; k <= 3; k++) begin
      vpulse();
      chk($sformatf("down_vpos%0d", k), dut.vpos, 128 + 2 * k);
    end
    chk("down_v_up", bus.v_up, 0);
    chk("vreset_line", dut.line, 0);

    // Upward mag 2 from 134 to 18, then top bounce with seg 0
    hit(3'd1);
    for (int k = 0; k < 58; k++) vpulse();
    chk("up_vpos18", dut.vpos, 18);
    chk("up_v_up", bus.v_up, 1);
    hit(3'd0);
    w0 = wall_cnt;
    vpulse();
    chk("top_vpos", dut.vpos, 16);
    chk("top_v_up", bus.v_up, 0);
    chk("top_mag", dut.mag, 3);
    chk("top_wall", wall_cnt - w0, WALL_EXP);

    // Downward mag 3 from 16 to 250, then bottom bounce with seg 7
    for (int k = 0; k < 78; k++) vpulse();
    chk("down_vpos250", dut.vpos, 250);
    hit(3'd7);
    w0 = wall_cnt;
    vpulse();
    chk("bot_vpos", dut.vpos, 252);
    chk("bot_v_up", bus.v_up, 1);
    chk("bot_wall", wall_cnt - w0, WALL_EXP);
    vpulse();
    chk("bot_next_vpos", dut.vpos, 249);

    // Serve freezes position; hit during serve still latches
    bus.serve = 1'b1;
    for (int k = 0; k < 5; k++) vpulse();
    chk("serve_vpos", dut.vpos, 249);
    hit(3'd1);
    chk("serve_hit_mag", dut.mag, 2);
    chk("serve_hit_v_up", bus.v_up, 1);
    vpulse();
    chk("serve_vpos2", dut.vpos, 249);
    bus.serve = 1'b0;
    vpulse();
    chk("after_serve_vpos", dut.vpos, 247);

    // Simultaneous hit and frame step: old velocity moves, new one latches
    hit(3'd5);
    chk("seg5_mag", dut.mag, 1);
    chk("seg5_v_up", bus.v_up, 0);
    @(negedge clk_drv);
    bus.pad_seg = 3'd0; bus.hit_n = 1'b0; bus.vreset = 1'b1;
    repeat (2) @(negedge clk_drv);
    bus.hit_n = 1'b1; bus.vreset = 1'b0;
    repeat (2) @(negedge clk_drv);
    chk("simul_vpos", dut.vpos, 248);
    chk("simul_v_up", bus.v_up, 1);
    chk("simul_mag", dut.mag, 3);
    vpulse();
    chk("simul_next_vpos", dut.vpos, 245);

    // Line counter priority and wrap, position frozen
    bus.serve = 1'b1;
    for (int k = 0; k < 3; k++) hpulse();
    chk("pre_both_line", dut.line, 3);
    @(negedge clk_drv); bus.hreset = 1'b1; bus.vreset = 1'b1;
    repeat (2) @(negedge clk_drv); bus.hreset = 1'b0; bus.vreset = 1'b0;
    repeat (2) @(negedge clk_drv);
    chk("both_line", dut.line, 0);
    for (int k = 0; k < 246; k++) hpulse();
    chk("line246_vvid_n", bus.vvid_n, 0);
    for (int k = 0; k < 15; k++) hpulse();
    chk("line_last", dut.line, 261);
    chk("line_last_vvid_n", bus.vvid_n, 1);
    hpulse();
    chk("line_wrap", dut.line, 0);

    // Asynchronous reset mid-frame while ball is on screen
    vpulse();
    for (int k = 0; k < 246; k++) hpulse();
    chk("pre_rst_vvid_n", bus.vvid_n, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_line", dut.line, 0);
    chk("arst_vpos", dut.vpos, 128);
    chk("arst_vvid_n", bus.vvid_n, 1);
    chk("arst_v_up", bus.v_up, 0);
    chk("arst_mag", dut.mag, 0);
    repeat (2) @(negedge clk_drv);
    rst = 1'b0;
    bus.serve = 1'b0;
    repeat (2) @(negedge clk_drv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound on run time
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
